// File: rtl/copro_fifo_bridge_if.sv
// Bus bundle between the mailbox bridge, the two Avalon FIFO ports and the accelerator core.
// master = bridge side, slave = FIFO/core side.
interface copro_fifo_bridge_if #(
    parameter int DATA_W = 32
);
    logic              fifo_rd_read;
    logic [DATA_W-1:0] fifo_rd_readdata;
    logic              fifo_rd_waitrequest;
    logic              fifo_wr_write;
    logic [DATA_W-1:0] fifo_wr_writedata;
    logic              fifo_wr_waitrequest;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [7:0]        cmd_opcode;
    logic [7:0]        cmd_tag;
    logic [15:0]       cmd_len;
    logic              pl_valid;
    logic              pl_ready;
    logic [DATA_W-1:0] pl_data;
    logic              pl_last;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              res_last;

    modport master (
        output fifo_rd_read, input fifo_rd_readdata, fifo_rd_waitrequest,
        output fifo_wr_write, fifo_wr_writedata, input fifo_wr_waitrequest,
        output cmd_valid, cmd_opcode, cmd_tag, cmd_len, input cmd_ready,
        output pl_valid, pl_data, pl_last, input pl_ready,
        input res_valid, res_data, res_last, output res_ready
    );

    modport slave (
        input fifo_rd_read, output fifo_rd_readdata, fifo_rd_waitrequest,
        input fifo_wr_write, fifo_wr_writedata, output fifo_wr_waitrequest,
        input cmd_valid, cmd_opcode, cmd_tag, cmd_len, output cmd_ready,
        input pl_valid, pl_data, pl_last, output pl_ready,
        output res_valid, res_data, res_last, input res_ready
    );
endinterface

// File: rtl/copro_fifo_bridge.sv
// Fabric endpoint of the HPS mailbox FIFO pair: header/payload fetch, result return, trailer and status.
// Optional command watchdog enabled by defining COPRO_BRIDGE_WDT_EN.
module copro_fifo_bridge #(
    parameter int DATA_W     = 32,
    parameter int BUF_DEPTH  = 2,
    parameter int WDT_CYCLES = 1000000
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    copro_fifo_bridge_if.master   io,
    output logic [31:0]           status
);
    if (DATA_W != 32) begin : g_bad_data_w
        $error("copro_fifo_bridge: DATA_W must be 32");
    end
    if (BUF_DEPTH != 2) begin : g_bad_buf_depth
        $error("copro_fifo_bridge: BUF_DEPTH must be 2");
    end
    if (WDT_CYCLES < 2) begin : g_bad_wdt
        $error("copro_fifo_bridge: WDT_CYCLES must be at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_HDR = 3'd1, S_CMD = 3'd2, S_PL = 3'd3, S_RES = 3'd4, S_TRL = 3'd5
    } state_t;

    localparam logic [1:0] BUF_FULL = 2'(BUF_DEPTH);

    state_t            state_q, state_d;
    logic [7:0]        opcode_q, opcode_d, tag_q, tag_d, last_tag_q, last_tag_d;
    logic [15:0]       len_q, len_d, fetch_cnt_q, fetch_cnt_d, pop_cnt_q, pop_cnt_d;
    logic [15:0]       res_cnt_q, res_cnt_d, done_cnt_q, done_cnt_d;
    logic [DATA_W-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
    logic              rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [1:0]        occ_q, occ_d;
    logic              res_done_q, res_done_d;
    logic              res_active, res_hs, rd_fire, push, pop, pl_valid_w, pl_last_w;
    logic [7:0]        trl_op;
    logic              wdt_flag;

`ifdef COPRO_BRIDGE_WDT_EN
    logic [31:0]       wdt_cnt_q, wdt_cnt_d;
    logic              wdt_hit_q, wdt_hit_d, wdt_flag_q, wdt_flag_d;
    assign trl_op   = wdt_hit_q ? 8'hEE : 8'hA5;
    assign wdt_flag = wdt_flag_q;
`else
    assign trl_op   = 8'hA5;
    assign wdt_flag = 1'b0;
`endif

    assign pl_valid_w = (state_q == S_PL) && (occ_q != 2'd0);
    assign pl_last_w  = pl_valid_w && (pop_cnt_q == len_q - 16'd1);
    assign pop        = pl_valid_w && io.pl_ready;
    // Results stream straight through to the write FIFO until the last one is taken.
    assign res_active = ((state_q == S_PL) || (state_q == S_RES)) && !res_done_q;
    assign res_hs     = res_active && io.res_valid && !io.fifo_wr_waitrequest;

    assign io.cmd_valid  = (state_q == S_CMD);
    assign io.cmd_opcode = opcode_q;
    assign io.cmd_tag    = tag_q;
    assign io.cmd_len    = len_q;
    assign io.pl_valid   = pl_valid_w;
    assign io.pl_data    = rd_ptr_q ? buf1_q : buf0_q;
    assign io.pl_last    = pl_last_w;
    assign status = {done_cnt_q, last_tag_q, 3'b000, wdt_flag,
                     (state_q != S_IDLE) && (state_q != S_HDR), state_q};

    always_comb begin
        io.fifo_rd_read = (state_q == S_HDR) ||
                          ((state_q == S_PL) && (fetch_cnt_q != 16'd0) && (occ_q < BUF_FULL));
        io.fifo_wr_write     = 1'b0;
        io.fifo_wr_writedata = '0;
        io.res_ready         = 1'b0;
        if (res_active) begin
            io.fifo_wr_write     = io.res_valid;
            io.fifo_wr_writedata = io.res_data;
            io.res_ready         = !io.fifo_wr_waitrequest;
        end else if (state_q == S_TRL) begin
            io.fifo_wr_write     = 1'b1;
            io.fifo_wr_writedata = {trl_op, tag_q, res_cnt_q};
        end
    end

    assign rd_fire = io.fifo_rd_read && !io.fifo_rd_waitrequest;
    assign push    = rd_fire && (state_q == S_PL);

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        tag_d       = tag_q;
        len_d       = len_q;
        last_tag_d  = last_tag_q;
        done_cnt_d  = done_cnt_q;
        buf0_d      = buf0_q;
        buf1_d      = buf1_q;
        rd_ptr_d    = rd_ptr_q ^ pop;
        wr_ptr_d    = wr_ptr_q ^ push;
        occ_d       = occ_q + {1'b0, push} - {1'b0, pop};
        fetch_cnt_d = fetch_cnt_q - {15'd0, push};
        pop_cnt_d   = pop_cnt_q + {15'd0, pop};
        res_cnt_d   = res_cnt_q + {15'd0, res_hs};
        res_done_d  = res_done_q | (res_hs && io.res_last);
`ifdef COPRO_BRIDGE_WDT_EN
        wdt_hit_d   = wdt_hit_q;
        wdt_flag_d  = wdt_flag_q;
        // Counts only while waiting in S_RES; any accepted result restarts the window.
        wdt_cnt_d   = (state_q == S_RES && !res_hs) ? wdt_cnt_q + 32'd1 : 32'd0;
`endif
        if (push) begin
            if (wr_ptr_q) buf1_d = io.fifo_rd_readdata;
            else          buf0_d = io.fifo_rd_readdata;
        end

        case (state_q)
            S_IDLE: state_d = S_HDR;
            S_HDR: if (rd_fire) begin
                opcode_d   = io.fifo_rd_readdata[31:24];
                tag_d      = io.fifo_rd_readdata[23:16];
                len_d      = io.fifo_rd_readdata[15:0];
                res_cnt_d  = 16'd0;
                res_done_d = 1'b0;
`ifdef COPRO_BRIDGE_WDT_EN
                wdt_hit_d  = 1'b0;
`endif
                state_d    = S_CMD;
            end
            S_CMD: if (io.cmd_ready) begin
                fetch_cnt_d = len_q;
                pop_cnt_d   = 16'd0;
                rd_ptr_d    = 1'b0;
                wr_ptr_d    = 1'b0;
                occ_d       = 2'd0;
                state_d     = (len_q == 16'd0) ? S_RES : S_PL;
            end
            S_PL: if (pop && pl_last_w) state_d = S_RES;
            S_RES: begin
                if (res_done_q) state_d = S_TRL;
`ifdef COPRO_BRIDGE_WDT_EN
                else if (!res_hs && wdt_cnt_q == 32'(WDT_CYCLES - 1)) begin
                    wdt_hit_d  = 1'b1;
                    wdt_flag_d = 1'b1;
                    state_d    = S_TRL;
                end
`endif
            end
            S_TRL: if (!io.fifo_wr_waitrequest) begin
                last_tag_d = tag_q;
                done_cnt_d = done_cnt_q + 16'd1;
                state_d    = S_HDR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q     <= S_IDLE;
            opcode_q    <= '0;
            tag_q       <= '0;
            len_q       <= '0;
            last_tag_q  <= '0;
            done_cnt_q  <= '0;
            buf0_q      <= '0;
            buf1_q      <= '0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            occ_q       <= '0;
            fetch_cnt_q <= '0;
            pop_cnt_q   <= '0;
            res_cnt_q   <= '0;
            res_done_q  <= 1'b0;
`ifdef COPRO_BRIDGE_WDT_EN
            wdt_cnt_q   <= '0;
            wdt_hit_q   <= 1'b0;
            wdt_flag_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            tag_q       <= tag_d;
            len_q       <= len_d;
            last_tag_q  <= last_tag_d;
            done_cnt_q  <= done_cnt_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            occ_q       <= occ_d;
            fetch_cnt_q <= fetch_cnt_d;
            pop_cnt_q   <= pop_cnt_d;
            res_cnt_q   <= res_cnt_d;
            res_done_q  <= res_done_d;
`ifdef COPRO_BRIDGE_WDT_EN
            wdt_cnt_q   <= wdt_cnt_d;
            wdt_hit_q   <= wdt_hit_d;
            wdt_flag_q  <= wdt_flag_d;
`endif
        end
    end
endmodule

// File: tb/tb_copro_fifo_bridge.sv
// Bench for copro_fifo_bridge: directed command table, reset/watchdog sequences and randomized
// traffic checked against a queue model of the FIFOs and the core.
module tb_copro_fifo_bridge;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] status;

    copro_fifo_bridge_if #(.DATA_W(32)) bus();

    copro_fifo_bridge #(.DATA_W(32), .BUF_DEPTH(2), .WDT_CYCLES(16)) dut (
        .clk_clk(clk), .reset_reset_n(rst_n), .io(bus), .status(status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hdr;
        logic [31:0] pl[8];
        logic [31:0] res[4];
        int          nres;
        int          rdw, wrw, plr;
        logic [31:0] exp_trl;
    } vec_t;

    vec_t        tbl[4];
    int          checks = 0, errors = 0, done_model = 0, res_cycles = 0;
    logic [31:0] src_q[$], res_q[$], exp_pl[$], exp_res[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.fifo_rd_readdata    = 32'd0;
        bus.fifo_rd_waitrequest = 1'b1;
        bus.fifo_wr_waitrequest = 1'b0;
        bus.cmd_ready           = 1'b0;
        bus.pl_ready            = 1'b0;
        bus.res_valid           = 1'b0;
        bus.res_data            = 32'd0;
        bus.res_last            = 1'b0;
    endtask

    function automatic logic outs_any();
        return bus.fifo_rd_read | bus.fifo_wr_write | (|bus.fifo_wr_writedata) | bus.cmd_valid |
               (|bus.cmd_opcode) | (|bus.cmd_tag) | (|bus.cmd_len) | bus.pl_valid |
               (|bus.pl_data) | bus.pl_last | bus.res_ready | (|status);
    endfunction

    // Runs one command. src_q holds header+payload, exp_pl the payload, res_q the core's results.
    // rdw: 0 none / 1 toggle / 2 random read stalls; wrw: 0 none / 1 random / 2 four-cycle trailer
    // stall; plr: 0 ready / 1 pl_ready low for 5 payload cycles / 2 random cmd/pl ready.
    task automatic run_cmd(input logic [31:0] hdr, input int nres, input int rdw, input int wrw,
                           input int plr, input logic [31:0] exp_trl, input logic exp_wdt);
        int n, pushed, popped, wr_cnt, pl_cyc, trl_cyc, last_pop;
        logic acc, fin, hdr_rd;
        logic [2:0] st;
        n = int'(hdr[15:0]);
        exp_res = res_q;
        pushed = 0; popped = 0; wr_cnt = 0; pl_cyc = 0; trl_cyc = 0; last_pop = -10;
        acc = 1'b0; fin = 1'b0; hdr_rd = 1'b0; res_cycles = 0;
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            @(negedge clk);
            st = status[2:0];
            if (st == 3'd3) pl_cyc++;
            if (st == 3'd4) res_cycles++;
            if (st == 3'd5) trl_cyc++;
            bus.fifo_rd_readdata    = (src_q.size() > 0) ? src_q[0] : 32'hDEAD_BEEF;
            bus.fifo_rd_waitrequest = (src_q.size() == 0) ||
                                      (rdw == 1 && cyc[0]) || (rdw == 2 && $urandom_range(0, 2) == 0);
            bus.fifo_wr_waitrequest = (wrw == 1 && $urandom_range(0, 3) == 0) ||
                                      (wrw == 2 && st == 3'd5 && trl_cyc <= 4);
            bus.cmd_ready = (plr != 2) || ($urandom_range(0, 1) == 1);
            bus.pl_ready  = (plr == 0) || (plr == 1 && pl_cyc > 5) ||
                            (plr == 2 && $urandom_range(0, 1) == 1);
            bus.res_valid = acc && res_q.size() > 0 && (wrw != 1 || $urandom_range(0, 3) != 0);
            bus.res_data  = (res_q.size() > 0) ? res_q[0] : 32'd0;
            bus.res_last  = (res_q.size() == 1);
            #1;
            if (bus.cmd_valid && bus.cmd_ready) begin
                chk("cmd_opcode", 32'(bus.cmd_opcode), 32'(hdr[31:24]));
                chk("cmd_tag", 32'(bus.cmd_tag), 32'(hdr[23:16]));
                chk("cmd_len", 32'(bus.cmd_len), 32'(hdr[15:0]));
                acc = 1'b1;
            end
            if (st == 3'd3) begin
                chk("rd_read_gate", 32'(bus.fifo_rd_read), 32'(pushed < n && pushed - popped < 2));
                chk("pl_valid", 32'(bus.pl_valid), 32'(pushed > popped));
            end
            if (bus.pl_valid && bus.pl_ready) begin
                if (popped >= n) chk("pl_extra_word", popped, n - 1);
                else begin
                    chk("pl_data", bus.pl_data, exp_pl[popped]);
                    chk("pl_last", 32'(bus.pl_last), 32'(popped == n - 1));
                end
                if (rdw == 0 && plr == 0 && popped > 0) chk("pl_back_to_back", cyc, last_pop + 1);
                last_pop = cyc;
                popped++;
            end
            if (bus.fifo_rd_read && !bus.fifo_rd_waitrequest) begin
                void'(src_q.pop_front());
                if (hdr_rd) pushed++;
                hdr_rd = 1'b1;
            end
            if (nres > 0 && acc && res_q.size() == 0 && (st == 3'd3 || st == 3'd4))
                chk("res_ready_after_last", 32'(bus.res_ready), 0);
            if (bus.res_valid && bus.res_ready) begin
                chk("res_to_fifo_write", 32'(bus.fifo_wr_write), 1);
                void'(res_q.pop_front());
            end
            if (st == 3'd5 && bus.fifo_wr_waitrequest) begin
                chk("trl_hold_write", 32'(bus.fifo_wr_write), 1);
                chk("trl_hold_data", bus.fifo_wr_writedata, exp_trl);
            end
            if (bus.fifo_wr_write && !bus.fifo_wr_waitrequest) begin
                if (wr_cnt < nres) chk("res_word", bus.fifo_wr_writedata, exp_res[wr_cnt]);
                else begin
                    chk("trailer", bus.fifo_wr_writedata, exp_trl);
                    chk("trailer_state", 32'(st), 5);
                    fin = 1'b1;
                end
                wr_cnt++;
            end
        end
        drive_idle();
        chk("cmd_complete", 32'(fin), 1);
        chk("payload_count", popped, n);
        chk("src_drained", src_q.size(), 0);
        if (fin) done_model++;
        @(negedge clk);
        chk("status_state", 32'(status[2:0]), 1);
        chk("status_tag", 32'(status[15:8]), 32'(hdr[23:16]));
        chk("status_done_cnt", 32'(status[31:16]), 32'(done_model[15:0]));
        chk("status_wdt", 32'(status[4]), 32'(exp_wdt));
    endtask

    task automatic load_cmd(input logic [31:0] hdr, input logic [31:0] pl[8], input int cnt_pl,
                            input logic [31:0] rs[4], input int nres);
        src_q.delete(); exp_pl.delete(); res_q.delete();
        src_q.push_back(hdr);
        for (int i = 0; i < cnt_pl; i++) begin
            src_q.push_back(pl[i]);
            exp_pl.push_back(pl[i]);
        end
        for (int i = 0; i < nres; i++) res_q.push_back(rs[i]);
    endtask

    initial begin
        logic [31:0] hdr, trl;
        logic [31:0] pl[8], rs[4];
        int          n, nres;

        tbl[0] = '{32'h10070003, '{32'h11, 32'h22, 32'h33, 0, 0, 0, 0, 0},
                   '{32'hAA, 32'hBB, 0, 0}, 2, 0, 0, 0, 32'hA5070002};
        tbl[1] = '{32'h20050000, '{0, 0, 0, 0, 0, 0, 0, 0},
                   '{32'hCC, 0, 0, 0}, 1, 0, 0, 0, 32'hA5050001};
        tbl[2] = '{32'h40060006, '{32'h101, 32'h202, 32'h303, 32'h404, 32'h505, 32'h606, 0, 0},
                   '{32'h1234, 0, 0, 0}, 1, 1, 0, 1, 32'hA5060001};
        tbl[3] = '{32'h50080001, '{32'h77, 0, 0, 0, 0, 0, 0, 0},
                   '{32'h1, 32'h2, 32'h3, 0}, 3, 0, 2, 0, 32'hA5080003};

        drive_idle();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'(outs_any()), 0);
        rst_n = 1'b1;
        #1;
        chk("post_reset_idle", 32'(status[2:0]), 0);
        chk("post_reset_no_read", 32'(bus.fifo_rd_read), 0);
        @(negedge clk);
        chk("hdr_state", 32'(status[2:0]), 1);
        chk("hdr_read", 32'(bus.fifo_rd_read), 1);

        for (int i = 0; i < 4; i++) begin
            load_cmd(tbl[i].hdr, tbl[i].pl, int'(tbl[i].hdr[15:0]), tbl[i].res, tbl[i].nres);
            run_cmd(tbl[i].hdr, tbl[i].nres, tbl[i].rdw, tbl[i].wrw, tbl[i].plr, tbl[i].exp_trl, 1'b0);
        end

        for (int k = 0; k < 15; k++) begin
            n    = $urandom_range(0, 7);
            nres = $urandom_range(1, 4);
            hdr  = {8'($urandom), 8'($urandom), 16'(n)};
            for (int i = 0; i < 8; i++) pl[i] = $urandom;
            for (int i = 0; i < 4; i++) rs[i] = $urandom;
            trl  = {8'hA5, hdr[23:16], 16'(nres)};
            load_cmd(hdr, pl, n, rs, nres);
            run_cmd(hdr, nres, 2, 1, 2, trl, 1'b0);
        end

        // Reset while the payload is half fetched.
        for (int i = 0; i < 8; i++) pl[i] = 32'hC0DE_0000 + i;
        load_cmd(32'h60010004, pl, 4, rs, 0);
        for (int cyc = 0; cyc < 50 && !(status[2:0] == 3'd3 && bus.pl_valid); cyc++) begin
            @(negedge clk);
            bus.fifo_rd_readdata    = (src_q.size() > 0) ? src_q[0] : 32'd0;
            bus.fifo_rd_waitrequest = (src_q.size() == 0);
            bus.cmd_ready           = 1'b1;
            bus.pl_ready            = 1'b0;
            #1;
            if (bus.fifo_rd_read && !bus.fifo_rd_waitrequest) void'(src_q.pop_front());
        end
        chk("mid_pl_reached", 32'(status[2:0]), 3);
        rst_n = 1'b0;
        #1;
        chk("mid_pl_reset_outputs", 32'(outs_any()), 0);
        src_q.delete();
        drive_idle();
        done_model = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_reset_idle", 32'(status[2:0]), 0);
        chk("mid_reset_no_read", 32'(bus.fifo_rd_read), 0);
        @(negedge clk);
        chk("mid_reset_hdr_state", 32'(status[2:0]), 1);
        chk("mid_reset_hdr_read", 32'(bus.fifo_rd_read), 1);
        load_cmd(tbl[0].hdr, tbl[0].pl, 3, tbl[0].res, 2);
        run_cmd(tbl[0].hdr, 2, 0, 0, 0, 32'hA5070002, 1'b0);

`ifdef COPRO_BRIDGE_WDT_EN
        load_cmd(32'h30090000, pl, 0, rs, 0);
        run_cmd(32'h30090000, 0, 0, 0, 0, 32'hEE090000, 1'b1);
        chk("wdt_res_cycles", res_cycles, 16);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/copro_fifo_bridge.md
Name: copro_fifo_bridge

Overview:
Fabric-side endpoint of the HPS mailbox FIFO pair. Acts as Avalon-MM master on the HPS→coprocessor FIFO read port and the coprocessor→HPS FIFO write port. Parses framed commands and streams payload words to the accelerator core. Returns the accelerator's result words followed by a trailer word, and drives a status word onto the status PIO. One command in flight at a time.

Parameters:
DATA_W, 32, FIFO and stream word width (fixed at 32; header/trailer layouts assume it)
BUF_DEPTH, 2, payload skid buffer entries (only 2 supported)
WDT_CYCLES, 1000000, watchdog limit in clk_clk cycles (used only with COPRO_BRIDGE_WDT_EN)

Ports:
clk_clk  in  1  single clock
reset_reset_n  in  1  asynchronous active-low reset
fifo_rd_read  out  1  Avalon read request to HPS→copro FIFO
fifo_rd_readdata  in  32  read data, valid when read=1 and waitrequest=0
fifo_rd_waitrequest  in  1  read stall (FIFO empty)
fifo_wr_write  out  1  Avalon write request to copro→HPS FIFO
fifo_wr_writedata  out  32  write data
fifo_wr_waitrequest  in  1  write stall (FIFO full)
cmd_valid  out  1  command header valid
cmd_ready  in  1  core accepts header
cmd_opcode  out  8  header[31:24]
cmd_tag  out  8  header[23:16]
cmd_len  out  16  header[15:0], payload word count N
pl_valid  out  1  payload word valid
pl_ready  in  1  core accepts payload word
pl_data  out  32  payload word
pl_last  out  1  final payload word
res_valid  in  1  result word valid
res_ready  out  1  bridge accepts result word
res_data  in  32  result word
res_last  in  1  final result word of command
status  out  32  to pio_status_export

Behaviour:
- Avalon transfer completes in the cycle request=1 and waitrequest=0. Read data is captured in that same cycle (zero read latency). A request is held with stable data until it completes.
- Reset: all outputs 0, buffer empty, counters 0, state S_IDLE. Reset mid-operation abandons the command. FIFO contents are not touched.
- FSM (status[2:0] code):
  - S_IDLE(0): unconditionally go to S_HDR next cycle.
  - S_HDR(1): fifo_rd_read=1. On completion, latch opcode/tag/len and go to S_CMD.
  - S_CMD(2): cmd_valid=1 with latched fields. On cmd_ready, go to S_PL with fetch_cnt=N; if N=0, go directly to S_RES.
  - S_PL(3): fifo_rd_read=1 while fetch_cnt>0 and buffer occupancy <2 (registered). Each completed read pushes a word and decrements fetch_cnt. pl_valid=occupancy>0. A pop happens on pl_valid&pl_ready. pl_last=1 on the Nth word. Simultaneous push and pop leaves occupancy unchanged; 1 word/cycle is sustained with pl_ready=1. When the Nth word is popped, go to S_RES.
  - S_RES(4): waiting for res_done. When res_done=1, go to S_TRL.
  - S_TRL(5): fifo_wr_write=1 with writedata=trailer. On completion, update status and go to S_HDR.
- Result path is active in S_PL and S_RES while res_done=0:
  - fifo_wr_write=res_valid, fifo_wr_writedata=res_data, res_ready=~fifo_wr_waitrequest (combinational).
  - Each handshake increments res_cnt (16-bit, wraps mod 2^16).
  - A handshake with res_last sets res_done. res_ready is 0 afterwards until the next command.
  - S_PL never exits before the payload drains, even if res_done is already set.
- res_cnt and res_done clear on entry to S_CMD.
- Trailer: [31:24]=8'hA5 (normal) or 8'hEE (watchdog), [23:16]=tag, [15:0]=res_cnt.
- status:
  - [2:0] state code
  - [3] busy (state≠S_HDR, S_IDLE)
  - [4] watchdog sticky flag
  - [7:5] 0
  - [15:8] tag of last trailer written
  - [31:16] completed-command count (wraps)

Optional Feature:
COPRO_BRIDGE_WDT_EN:
- Defined:
  - A cycle counter clears on entry to S_RES and on every result handshake.
  - If it reaches WDT_CYCLES in S_RES with res_done=0, go to S_TRL with trailer opcode 8'hEE and set status[4] (cleared only by reset).
  - Results arriving later are not accepted until the next command; software resets the core.
- Undefined: S_RES waits indefinitely, status[4] is tied to 0, and no counter logic is present.

Test Plan:
1. Header 0x10070003, payload 0x11/0x22/0x33, no waitrequests, pl_ready=1 → cmd 0x10/0x07/3; pl_data 0x11,0x22,0x33 on consecutive cycles with pl_last on 0x33. Results 0xAA, 0xBB(last) → writes 0xAA, 0xBB, 0xA5070002; status[15:8]=0x07, status[31:16]=1.
2. Header 0x20050000 → cmd presented, no payload read. One result 0xCC(last) → writes 0xCC, 0xA5050001.
3. N=6, fifo_rd_waitrequest toggling every cycle, pl_ready low for 5 cycles → fifo_rd_read drops at occupancy 2; all 6 words are delivered in order, with none dropped or duplicated.
4. fifo_wr_waitrequest high 4 cycles during trailer → fifo_wr_write and writedata held stable, single trailer written, state stays 5 until completion.
5. reset_reset_n low mid-S_PL → all outputs 0 immediately. After release: one cycle in S_IDLE, then fifo_rd_read=1 in S_HDR.
6. COPRO_BRIDGE_WDT_EN, WDT_CYCLES=16, header 0x30090000, no results → after 16 cycles in S_RES, trailer 0xEE090000 is written and status[4]=1.
